writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 12 +
 rtl/wb_fifo.sv | 49 ++++
 rtl/writeback_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared widths, defaults and writeback entry record
package writeback_arbiter_pkg;
    localparam int REG_ADDR_W       = 5;
    localparam int DATA_W           = 32;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - multdiv result FIFO, power-of-two depth, no same-cycle bypass
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  wb_entry_t                    push_entry_i,
    input  logic                         pop_i,
    output wb_entry_t                    head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    wb_entry_t     mem_q [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_i && !reset) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - pipeline vs multdiv register-file write arbitration
// with starvation stall and multdiv busy scoreboard
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  md_ready,
    input  logic                  md_issue,
    input  logic [REG_ADDR_W-1:0] md_issue_rd,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegC,
    output logic                  busyA,
    output logic                  busyB,
    output logic                  busyC,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]     data_writeReg,
    output logic                  wb_stall
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                  pipe_act, md_push, fifo_pop, fifo_full, fifo_empty;
    wb_entry_t             fifo_head;
    logic [CW-1:0]         fifo_count;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [31:0]           busy_q, busy_d;

    assign pipe_act = pipe_we && (pipe_rd != '0);
    assign md_ready = !fifo_full;
    // rd=0 offers are handshaken but never enter the FIFO.
    assign md_push  = md_valid && md_ready && (md_rd != '0);
    assign fifo_pop = !pipe_act && !fifo_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock        (clock),
        .reset        (ctrl_reset),
        .push_i       (md_push),
        .push_entry_i ('{rd: md_rd, data: md_data}),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    always_comb begin
        we_d     = 1'b0;
        reg_d    = reg_q;
        data_d   = data_q;
        starve_d = starve_q;
        busy_d   = busy_q;
        if (pipe_act) begin
            we_d   = 1'b1;
            reg_d  = pipe_rd;
            data_d = pipe_data;
        end else if (fifo_pop) begin
            we_d   = 1'b1;
            reg_d  = fifo_head.rd;
            data_d = fifo_head.data;
        end
        if (fifo_empty || fifo_pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
        // Clear before set so a same-cycle issue to the popped register wins.
        if (fifo_pop)
            busy_d[fifo_head.rd] = 1'b0;
        if (md_issue && (md_issue_rd != '0))
            busy_d[md_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            we_q     <= 1'b0;
            reg_q    <= '0;
            data_q   <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            we_q     <= we_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = reg_q;
    assign data_writeReg    = data_q;
    assign wb_stall         = (starve_q == SW'(STARVE_LIMIT)) || (fifo_count == CW'(FIFO_DEPTH));
    assign busyA            = busy_q[ctrl_readRegA];
    assign busyB            = busy_q[ctrl_readRegB];
    assign busyC            = busy_q[ctrl_readRegC];
endmodule
